load_data_unit: RTL and testbench

- Load-side counterpart of the store byte-mask path.
- Accepts one load request (byte address plus the standard memdata_width code) from the MEM stage and issues 8-byte-aligned read(s) to the data memory port.
- Extracts the addressed bytes from the returned 64-bit word(s), sign- or zero-extends them, and returns a 64-bit result over a valid/ready handshake.
- Loads that straddle an 8-byte boundary are handled as two memory beats.

---
 rtl/load_data_unit.sv | 191 +++++++++++++++++++
 tb/tb_load_data_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_data_unit.sv
// Load data unit: issues doubleword-aligned reads for a MEM-stage load, extracts the
// addressed bytes (splitting across two beats when needed) and returns the extended result.
module load_data_unit #(
  parameter int ADDR_W      = 64,
  parameter int ALLOW_SPLIT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_width,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_data,
  output logic              resp_err
);

  localparam int IDX_W = ADDR_W - 3;

  localparam logic [2:0] W_NONE = 3'b000;
  localparam logic [2:0] W_DW   = 3'b001;
  localparam logic [2:0] W_W    = 3'b010;
  localparam logic [2:0] W_HW   = 3'b011;
  localparam logic [2:0] W_B    = 3'b100;
  localparam logic [2:0] W_UW   = 3'b101;
  localparam logic [2:0] W_UHW  = 3'b110;
  localparam logic [2:0] W_UB   = 3'b111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } state_e;

  function automatic logic [3:0] size_of(input logic [2:0] width);
    logic [3:0] sz;
    case (width)
      W_DW:         sz = 4'd8;
      W_W, W_UW:    sz = 4'd4;
      W_HW, W_UHW:  sz = 4'd2;
      W_B, W_UB:    sz = 4'd1;
      default:      sz = 4'd0;
    endcase
    return sz;
  endfunction

  function automatic logic needs_split(input logic [2:0] off, input logic [2:0] width);
    return ({1'b0, off} + size_of(width)) > 4'd8;
  endfunction

  // Align the addressed byte to bit 0, then keep and extend the requested width.
  function automatic logic [63:0] extract(input logic [127:0] pair,
                                          input logic [2:0]   off,
                                          input logic [2:0]   width);
    logic [63:0] v;
    logic [63:0] r;
    v = 64'(pair >> {off, 3'b000});
    case (width)
      W_DW:    r = v;
      W_W:     r = {{32{v[31]}}, v[31:0]};
      W_HW:    r = {{48{v[15]}}, v[15:0]};
      W_B:     r = {{56{v[7]}},  v[7:0]};
      W_UW:    r = {32'd0, v[31:0]};
      W_UHW:   r = {48'd0, v[15:0]};
      W_UB:    r = {56'd0, v[7:0]};
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [2:0]         width_q;
  logic [63:0]        lo_q;
  logic [63:0]        resp_data_q;
  logic               resp_err_q;

  logic [IDX_W-1:0]   dw_idx;
  logic [IDX_W-1:0]   dw_idx_next;
  logic               split_q;
  logic               req_bad;
  logic [127:0]       rd_pair;
  logic [63:0]        result_nxt;

  assign dw_idx      = addr_q[ADDR_W-1:3];
  assign dw_idx_next = dw_idx + IDX_W'(1);
  assign split_q     = needs_split(addr_q[2:0], width_q);
  assign req_bad     = (req_width == W_NONE) ||
                       ((ALLOW_SPLIT == 0) && needs_split(req_addr[2:0], req_width));

  // Second beat feeds the result register directly alongside the held first beat.
  always_comb begin
    rd_pair = {64'd0, mem_rdata};
    if (state_q == WAIT1) rd_pair = {mem_rdata, lo_q};
  end

  assign result_nxt = extract(rd_pair, addr_q[2:0], width_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    resp_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_bad ? RESP : REQ0;
      end
      REQ0: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {dw_idx, 3'b000};
        if (mem_req_ready) state_d = WAIT0;
      end
      WAIT0: begin
        if (mem_rvalid) state_d = split_q ? REQ1 : RESP;
      end
      REQ1: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {dw_idx_next, 3'b000};
        if (mem_req_ready) state_d = WAIT1;
      end
      WAIT1: begin
        if (mem_rvalid) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, beat capture and result register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q      <= '0;
      width_q     <= 3'b000;
      lo_q        <= 64'd0;
      resp_data_q <= 64'd0;
      resp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            width_q <= req_width;
            if (req_bad) begin
              resp_data_q <= 64'd0;
              resp_err_q  <= 1'b1;
            end
          end
        end
        WAIT0: begin
          if (mem_rvalid) begin
            lo_q <= mem_rdata;
            if (!split_q) begin
              resp_data_q <= result_nxt;
              resp_err_q  <= 1'b0;
            end
          end
        end
        WAIT1: begin
          if (mem_rvalid) begin
            resp_data_q <= result_nxt;
            resp_err_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_data = resp_data_q;
  assign resp_err  = resp_err_q;

endmodule

// File: tb/tb_load_data_unit.sv
// Directed bench for load_data_unit: aligned, split, wrap, error, stall and reset cases
// against a small in-order memory responder.
module tb_load_data_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready;
  logic [63:0] req_addr;
  logic [2:0]  req_width;
  logic        mem_req_valid, mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata  = 64'd0;
  logic        resp_valid, resp_ready;
  logic [63:0] resp_data;
  logic        resp_err;

  logic        ns_req_valid, ns_req_ready;
  logic        ns_mem_req_valid, ns_mem_req_ready;
  logic [63:0] ns_mem_req_addr;
  logic        ns_mem_rvalid;
  logic [63:0] ns_mem_rdata;
  logic        ns_resp_valid, ns_resp_ready;
  logic [63:0] ns_resp_data;
  logic        ns_resp_err;

  int          n_checks = 0;
  int          n_errors = 0;
  int          acc_cnt = 0;
  int          mv_cnt = 0;
  int          ns_mv_cnt = 0;
  logic [63:0] acc_addr [16];
  logic        rv_suppress = 1'b0;
  logic        inject_rv = 1'b0;

  load_data_unit dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_width(req_width),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err)
  );

  load_data_unit #(.ALLOW_SPLIT(0)) dut_ns (
    .clk(clk), .rstn(rstn),
    .req_valid(ns_req_valid), .req_ready(ns_req_ready),
    .req_addr(req_addr), .req_width(req_width),
    .mem_req_valid(ns_mem_req_valid), .mem_req_ready(ns_mem_req_ready),
    .mem_req_addr(ns_mem_req_addr),
    .mem_rvalid(ns_mem_rvalid), .mem_rdata(ns_mem_rdata),
    .resp_valid(ns_resp_valid), .resp_ready(ns_resp_ready),
    .resp_data(ns_resp_data), .resp_err(ns_resp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    case (a)
      64'h1000:                return 64'h1122_3344_8566_7788;
      64'h2000:                return 64'hAABB_0000_0000_0000;
      64'h2008:                return 64'h0000_0000_0000_CCDD;
      64'h3000:                return 64'h0123_4567_89AB_CDEF;
      64'hFFFF_FFFF_FFFF_FFF8: return 64'h1234_5678_9ABC_DEF0;
      64'h0:                   return 64'h0FED_CBA9_8765_4321;
      default:                 return 64'hBAD0_BAD0_BAD0_BAD0;
    endcase
  endfunction

  // In-order memory: one read beat in the cycle after each accepted request.
  always @(posedge clk) begin
    mem_rvalid <= (mem_req_valid && mem_req_ready && !rv_suppress) || inject_rv;
    mem_rdata  <= (mem_req_valid && mem_req_ready) ? mem_word(mem_req_addr)
                                                    : 64'hBAD0_BAD0_BAD0_BAD0;
    if (mem_req_valid && mem_req_ready) begin
      acc_addr[acc_cnt % 16] <= mem_req_addr;
      acc_cnt <= acc_cnt + 1;
    end
    if (mem_req_valid)    mv_cnt    <= mv_cnt + 1;
    if (ns_mem_req_valid) ns_mv_cnt <= ns_mv_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic send_req(input logic [63:0] a, input logic [2:0] w);
    @(posedge clk); #1;
    req_addr  = a;
    req_width = w;
    req_valid = 1'b1;
    check_val("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Latency counts the handshake cycle and the first resp_valid cycle inclusively.
  task automatic wait_resp(output int lat);
    int c = 1;
    while (!resp_valid && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    check_val("resp_valid", 64'(resp_valid), 64'd1);
    lat = c + 1;
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check_val("idle_after_resp", 64'(req_ready), 64'd1);
  endtask

  task automatic load_case(input string tag, input logic [63:0] a, input logic [2:0] w,
                           input logic [63:0] exp_data, input int exp_lat);
    int lat;
    send_req(a, w);
    wait_resp(lat);
    check_val({tag, "_data"}, resp_data, exp_data);
    check_val({tag, "_err"}, 64'(resp_err), 64'd0);
    check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    finish_resp();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    check_val({tag, "_mem_req_valid"}, 64'(mem_req_valid), 64'd0);
    check_val({tag, "_mem_req_addr"}, mem_req_addr, 64'd0);
    check_val({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    check_val({tag, "_resp_data"}, resp_data, 64'd0);
    check_val({tag, "_resp_err"}, 64'(resp_err), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int lat;
    int c;
    rstn = 1'b0; req_valid = 1'b0; req_addr = 64'd0; req_width = 3'b000;
    mem_req_ready = 1'b1; resp_ready = 1'b0;
    ns_req_valid = 1'b0; ns_resp_ready = 1'b0;
    ns_mem_req_ready = 1'b1; ns_mem_rvalid = 1'b0; ns_mem_rdata = 64'd0;
    #2;
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rstn = 1'b1;

    base = acc_cnt;
    load_case("lb", 64'h1003, 3'b100, 64'hFFFF_FFFF_FFFF_FF85, 4);
    check_val("lb_reads", 64'(acc_cnt - base), 64'd1);
    check_val("lb_addr", acc_addr[base % 16], 64'h1000);

    load_case("lbu", 64'h1003, 3'b111, 64'h0000_0000_0000_0085, 4);
    load_case("lh",  64'h1002, 3'b011, 64'hFFFF_FFFF_FFFF_8566, 4);
    load_case("lhu", 64'h1006, 3'b110, 64'h0000_0000_0000_1122, 4);
    load_case("lwu", 64'h1004, 3'b101, 64'h0000_0000_1122_3344, 4);
    load_case("lw",  64'h1000, 3'b010, 64'hFFFF_FFFF_8566_7788, 4);
    load_case("ld",  64'h1000, 3'b001, 64'h1122_3344_8566_7788, 4);

    base = acc_cnt;
    load_case("lw_split", 64'h2006, 3'b010, 64'hFFFF_FFFF_CCDD_AABB, 6);
    check_val("split_reads", 64'(acc_cnt - base), 64'd2);
    check_val("split_addr0", acc_addr[base % 16], 64'h2000);
    check_val("split_addr1", acc_addr[(base + 1) % 16], 64'h2008);
    load_case("uhw_split", 64'h2007, 3'b110, 64'h0000_0000_0000_DDAA, 6);
    load_case("ld_split",  64'h2001, 3'b001, 64'hDDAA_BB00_0000_0000, 6);

    base = acc_cnt;
    load_case("uw_wrap", 64'hFFFF_FFFF_FFFF_FFFE, 3'b101, 64'h0000_0000_4321_1234, 6);
    check_val("wrap_addr0", acc_addr[base % 16], 64'hFFFF_FFFF_FFFF_FFF8);
    check_val("wrap_addr1", acc_addr[(base + 1) % 16], 64'h0);

    base = mv_cnt;
    send_req(64'h4000, 3'b000);
    wait_resp(lat);
    check_val("w0_err", 64'(resp_err), 64'd1);
    check_val("w0_data", resp_data, 64'd0);
    check_val("w0_lat", 64'(lat), 64'd2);
    finish_resp();
    check_val("w0_no_mem_req", 64'(mv_cnt - base), 64'd0);

    @(posedge clk); #1;
    req_addr = 64'h2006; req_width = 3'b010; ns_req_valid = 1'b1;
    check_val("ns_req_ready", 64'(ns_req_ready), 64'd1);
    @(posedge clk); #1;
    ns_req_valid = 1'b0;
    c = 1;
    while (!ns_resp_valid && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    check_val("ns_resp_valid", 64'(ns_resp_valid), 64'd1);
    check_val("ns_lat", 64'(c + 1), 64'd2);
    check_val("ns_err", 64'(ns_resp_err), 64'd1);
    check_val("ns_data", ns_resp_data, 64'd0);
    check_val("ns_mem_addr", ns_mem_req_addr, 64'd0);
    ns_resp_ready = 1'b1;
    @(posedge clk); #1;
    ns_resp_ready = 1'b0;
    check_val("ns_idle", 64'(ns_req_ready), 64'd1);
    check_val("ns_no_mem_req", 64'(ns_mv_cnt), 64'd0);

    base = acc_cnt;
    mem_req_ready = 1'b0;
    send_req(64'h3000, 3'b001);
    for (int i = 0; i < 5; i++) begin
      check_val("stall_mem_valid", 64'(mem_req_valid), 64'd1);
      check_val("stall_mem_addr", mem_req_addr, 64'h3000);
      check_val("stall_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b1;
    wait_resp(lat);
    req_valid = 1'b1; req_addr = 64'h5000; req_width = 3'b001;
    for (int i = 0; i < 3; i++) begin
      check_val("rstall_valid", 64'(resp_valid), 64'd1);
      check_val("rstall_data", resp_data, 64'h0123_4567_89AB_CDEF);
      check_val("rstall_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check_val("rstall_err", 64'(resp_err), 64'd0);
    finish_resp();
    check_val("stall_reads", 64'(acc_cnt - base), 64'd1);

    rv_suppress = 1'b1;
    send_req(64'h1000, 3'b001);
    @(posedge clk); #1;
    check_val("wait0_no_mem_req", 64'(mem_req_valid), 64'd0);
    rstn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rv_suppress = 1'b0;
    rstn = 1'b1;
    inject_rv = 1'b1;
    @(posedge clk); #1;
    inject_rv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_val("stale_resp_valid", 64'(resp_valid), 64'd0);
      check_val("stale_req_ready", 64'(req_ready), 64'd1);
      @(posedge clk); #1;
    end

    load_case("lb_after_rst", 64'h1003, 3'b100, 64'hFFFF_FFFF_FFFF_FF85, 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
